// File: rtl/cnn_pool_pkg.sv
// Shared types and sizing for the CNN pooling stage.
package cnn_pool_pkg;
  localparam int BIT_W    = 16;
  localparam int IN_W     = 8;
  localparam int N_FILT   = 8;
  localparam int POOL_W   = IN_W / 2;
  localparam int POOL_PIX = POOL_W * POOL_W;

  typedef logic signed [BIT_W-1:0] word_t;

  // Index width that stays at least one bit for degenerate 1-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pool_max2.sv
// Channel-parallel signed pairwise maximum; ties return operand a.
module pool_max2 #(
  parameter int W = 16,
  parameter int N = 8
) (
  input  logic signed [W-1:0] i_a   [N],
  input  logic signed [W-1:0] i_b   [N],
  output logic signed [W-1:0] o_max [N]
);
  always_comb begin
    for (int f = 0; f < N; f++) begin
      o_max[f] = (i_a[f] >= i_b[f]) ? i_a[f] : i_b[f];
    end
  end
endmodule

// File: rtl/maxpool2d_stream.sv
// Streaming 2x2 stride-2 max-pool with a half-row line buffer.
// Define MAXPOOL_FRAME_BUF_EN to add the flat pooled-frame output for the dense stage.
module maxpool2d_stream
  import cnn_pool_pkg::*;
#(
  parameter int bitWidth   = BIT_W,
  parameter int inputWidth = IN_W,
  parameter int numFilt    = N_FILT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [bitWidth-1:0] in_data  [numFilt],
  output logic                       out_valid,
  output logic signed [bitWidth-1:0] out_data [numFilt],
  output logic [idx_w((inputWidth/2)*(inputWidth/2))-1:0] out_idx,
  output logic                       frame_done
`ifdef MAXPOOL_FRAME_BUF_EN
  ,
  output logic signed [bitWidth-1:0] frame_matrix [(inputWidth/2)*(inputWidth/2)*numFilt],
  output logic                       frame_valid
`endif
);
  localparam int PW   = inputWidth / 2;
  localparam int PPIX = PW * PW;
  localparam int CW   = idx_w(inputWidth);
  localparam int IW   = idx_w(PPIX);
  localparam int HW   = idx_w(PW);

  logic [CW-1:0]              r_col, r_row;
  logic signed [bitWidth-1:0] r_hold [numFilt];
  logic signed [bitWidth-1:0] r_line [PW][numFilt];
  logic signed [bitWidth-1:0] r_out  [numFilt];
  logic                       r_out_valid, r_frame_done;
  logic [IW-1:0]              r_out_idx;

  logic signed [bitWidth-1:0] w_line_rd  [numFilt];
  logic signed [bitWidth-1:0] w_max_line [numFilt];
  logic signed [bitWidth-1:0] w_max_hold [numFilt];
  logic [HW-1:0]              w_half_col;
  logic [IW-1:0]              w_pidx;
  logic                       w_col_last, w_row_last, w_emit;

  always_comb begin
    w_half_col = HW'(r_col >> 1);
    w_pidx     = IW'(int'(r_row >> 1) * PW + int'(r_col >> 1));
    w_col_last = (r_col == CW'(inputWidth - 1));
    w_row_last = (r_row == CW'(inputWidth - 1));
    w_emit     = in_valid && r_row[0] && r_col[0];
    w_line_rd  = r_line[w_half_col];
  end

  // Odd-row/even-col merges the stored top pair into the hold register.
  pool_max2 #(.W(bitWidth), .N(numFilt)) u_max_line (
    .i_a   (w_line_rd),
    .i_b   (in_data),
    .o_max (w_max_line)
  );

  // Right-hand pixel against hold: feeds the line buffer and the output.
  pool_max2 #(.W(bitWidth), .N(numFilt)) u_max_hold (
    .i_a   (r_hold),
    .i_b   (in_data),
    .o_max (w_max_hold)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col        <= '0;
      r_row        <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_out_idx    <= '0;
      for (int f = 0; f < numFilt; f++) begin
        r_hold[f] <= '0;
        r_out[f]  <= '0;
        for (int p = 0; p < PW; p++) r_line[p][f] <= '0;
      end
    end else begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (in_valid) begin
        r_col <= w_col_last ? '0 : r_col + 1'b1;
        if (w_col_last) r_row <= w_row_last ? '0 : r_row + 1'b1;
        case ({r_row[0], r_col[0]})
          2'b00:   r_hold <= in_data;
          2'b01:   r_line[w_half_col] <= w_max_hold;
          2'b10:   r_hold <= w_max_line;
          default: begin
            r_out        <= w_max_hold;
            r_out_valid  <= 1'b1;
            r_out_idx    <= w_pidx;
            r_frame_done <= (w_pidx == IW'(PPIX - 1));
          end
        endcase
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out;
  assign out_idx    = r_out_idx;
  assign frame_done = r_frame_done;

`ifdef MAXPOOL_FRAME_BUF_EN
  logic signed [bitWidth-1:0] r_frame [PPIX*numFilt];
  logic                       r_frame_valid;

  // Valid spans from the last write of a frame to the first write of the next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_valid <= 1'b0;
      for (int i = 0; i < PPIX*numFilt; i++) r_frame[i] <= '0;
    end else if (w_emit) begin
      for (int f = 0; f < numFilt; f++) r_frame[int'(w_pidx)*numFilt + f] <= w_max_hold[f];
      r_frame_valid <= (w_pidx == IW'(PPIX - 1));
    end
  end

  assign frame_matrix = r_frame;
  assign frame_valid  = r_frame_valid;
`endif
endmodule

// File: doc/maxpool2d_stream.md
Name: maxpool2d_stream

Overview:
- Streaming 2x2, stride-2 max-pool stage between the conv/ReLU layer and the dense layer of the 2D CNN.
- Consumes one pixel per valid cycle in raster order; each pixel carries numFilt channel values.
- Emits one pooled pixel (numFilt values) per completed 2x2 window, reducing an inputWidth x inputWidth x numFilt map to a quarter of its size.
- Uses a half-row line buffer; no full-frame storage unless the optional feature is enabled.

Parameters:
bitWidth, 16, signed fixed-point word width (Q5.10 at default)
inputWidth, 8, input map height/width; must be even and >= 2
numFilt, 8, channels per pixel

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  in_data holds a valid pixel this cycle
in_data  input  numFilt x bitWidth (signed, unpacked)  channel values of the current pixel
out_valid  output  1  one-cycle pulse; out_data holds a pooled pixel
out_data  output  numFilt x bitWidth (signed, unpacked)  per-channel window maximum
out_idx  output  clog2((inputWidth/2)^2)  raster index of the pooled pixel in out_data
frame_done  output  1  pulses together with out_valid for the last pooled pixel of a frame

Behaviour:
- Reset is asynchronous on the falling edge of reset and held while reset=0.
  - On reset: out_valid=0, frame_done=0, out_idx=0, out_data all 0, col=row=0, line buffer and hold register cleared.
  - Reset mid-frame discards the partial frame; the next valid pixel is treated as (row 0, col 0).
- Counters:
  - col increments 0..inputWidth-1 on each in_valid.
  - At col wrap, row increments 0..inputWidth-1.
  - At row and col both at max, both wrap to 0 (frame boundary).
  - in_valid=0 stalls all state; there is no upstream backpressure.
- Per channel f, all comparisons are signed, and max(a,b) returns a when a>=b:
  - even row, even col: hold[f] <= in_data[f]
  - even row, odd col: line_buf[col/2][f] <= max(hold[f], in_data[f])
  - odd row, even col: hold[f] <= max(line_buf[col/2][f], in_data[f])
  - odd row, odd col: out_data[f] <= max(hold[f], in_data[f]); out_valid <= 1
- Latency: out_valid is asserted on the cycle after the odd-row/odd-col pixel is accepted. out_data holds its value until the next output.
- out_idx:
  - Increments after each output; wraps to 0 after (inputWidth/2)^2-1.
  - frame_done=1 exactly when the emitted out_idx = (inputWidth/2)^2-1.
- Output pulses: out_valid and frame_done are 0 in every cycle not listed above, including back-to-back frames.
- Line buffer: (inputWidth/2) x numFilt words. Words are only read at odd rows after being written in the preceding even row, so stale contents are never observed.
- Arithmetic: no growth or rounding; output width equals input width.

Optional Feature:
- Macro MAXPOOL_FRAME_BUF_EN.
- When defined:
  - Adds output frame_matrix: (inputWidth/2)^2*numFilt x bitWidth signed, flat, index = out_idx*numFilt + f. This is the flat array the dense stage consumes.
  - Adds output frame_valid.
  - Each pooled result is written into frame_matrix at its index on the out_valid cycle.
  - frame_valid rises with frame_done and falls on the first write of the next frame.
  - Reset clears frame_matrix and frame_valid to 0.
- When undefined: neither port nor any storage exists; behaviour is otherwise identical.

Decomposition:
- Package cnn_pool_pkg:
  - word_t (logic signed [bitWidth-1:0] at default width)
  - POOL_W = inputWidth/2
  - POOL_PIX = POOL_W*POOL_W
  - index-width localparams via $clog2
- Sub-module pool_max2:
  - Combinational numFilt-wide signed pairwise max.
  - Instantiated twice: line-buffer/hold path and output path.

Test Plan:
- Reset: pulse reset low mid-cycle with clk idle -> all outputs 0 immediately. Release and stream a 4x4x1 map with pixel value = raster index (0..15) -> out_data 5, 7, 13, 15; out_idx 0..3; frame_done only with the 15.
- Signed values: inputWidth=4, numFilt=2; channel 1 is all negative (-1024..-1039), channel 0 is the raster index -> channel 1 outputs -1024, -1026, -1032, -1034 and channel 0 outputs match the reset test.
- Stalls: default 8x8x8 map with in_valid randomly low ~50% -> outputs identical to the no-stall golden model (16 pooled pixels, each max of its window); no spurious out_valid.
- Back-to-back frames: two 8x8 frames with no gap, frame 2 = frame 1 + 1 -> 32 outputs; out_idx wraps 15->0; frame_done exactly twice; frame 2 results equal frame 1 results + 1.
- Reset mid-frame: assert reset after 37 pixels, then stream a full frame -> exactly 16 outputs, all matching the new frame only.
- MAXPOOL_FRAME_BUF_EN: after one 8x8x8 frame, frame_matrix[out_idx*8+f] matches the golden model and frame_valid=1. frame_valid drops on the first write of the next frame.
